// File: rtl/complex_divide_seq_if.sv
// Start/busy/done handshake and operand/result bus for the sequential complex divider.
interface complex_divide_seq_if;
  logic        start;
  logic [63:0] A;
  logic [63:0] B;
  logic [63:0] result;
  logic        busy;
  logic        done;
  logic        div_by_zero;

  modport master (output start, A, B, input result, busy, done, div_by_zero);
  modport slave  (input start, A, B, output result, busy, done, div_by_zero);
endinterface

// File: rtl/complex_divide_seq.sv
// Sequential complex divider A/B = A*conj(B)/|B|^2 on packed {real, imag} single-precision
// operands, sharing two multipliers, one adder/subtractor and one divider under an FSM.
package complex_divide_seq_pkg;
  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  // sig[26] is the leading one; sig[2:0] are guard, round and sticky. Denormals flush to zero.
  function automatic logic [31:0] round_pack(input logic s, input logic signed [10:0] e,
                                             input logic [26:0] sig);
    logic [24:0]        m;
    logic               inc;
    logic signed [10:0] ex;
    ex  = e;
    inc = sig[2] & (sig[3] | sig[1] | sig[0]);
    m   = {1'b0, sig[26:3]} + {24'd0, inc};
    if (m[24]) begin
      ex = ex + 11'sd1;
      m  = m >> 1;
    end
    if (ex >= 11'sd255) return {s, 8'hFF, 23'd0};
    if (ex <= 11'sd0)   return {s, 31'd0};
    return {s, ex[7:0], m[22:0]};
  endfunction

  function automatic logic [31:0] fp_mul(input logic [31:0] a, input logic [31:0] b);
    logic               s, za, zb, ia, ib;
    logic [47:0]        p;
    logic signed [10:0] e;
    s  = a[31] ^ b[31];
    za = (a[30:23] == 8'd0);
    zb = (b[30:23] == 8'd0);
    ia = (a[30:23] == 8'hFF);
    ib = (b[30:23] == 8'hFF);
    if ((ia && a[22:0] != 23'd0) || (ib && b[22:0] != 23'd0)) return QNAN;
    if (ia || ib) return (za || zb) ? QNAN : {s, 8'hFF, 23'd0};
    if (za || zb) return {s, 31'd0};
    p = {24'd0, 1'b1, a[22:0]} * {24'd0, 1'b1, b[22:0]};
    e = $signed({3'b0, a[30:23]}) + $signed({3'b0, b[30:23]}) - 11'sd127;
    if (p[47]) return round_pack(s, e + 11'sd1, {p[47:22], |p[21:0]});
    return round_pack(s, e, {p[46:21], |p[20:0]});
  endfunction

  function automatic logic [31:0] fp_div(input logic [31:0] a, input logic [31:0] b);
    logic               s, za, zb, ia, ib, st;
    logic [49:0]        num, dnm, q, r;
    logic signed [10:0] e;
    s  = a[31] ^ b[31];
    za = (a[30:23] == 8'd0);
    zb = (b[30:23] == 8'd0);
    ia = (a[30:23] == 8'hFF);
    ib = (b[30:23] == 8'hFF);
    if ((ia && a[22:0] != 23'd0) || (ib && b[22:0] != 23'd0)) return QNAN;
    if ((ia && ib) || (za && zb)) return QNAN;
    if (ia || zb) return {s, 8'hFF, 23'd0};
    if (ib || za) return {s, 31'd0};
    num = {1'b1, a[22:0], 26'd0};
    dnm = {26'd0, 1'b1, b[22:0]};
    q   = num / dnm;
    r   = num % dnm;
    st  = (r != 50'd0);
    e   = $signed({3'b0, a[30:23]}) - $signed({3'b0, b[30:23]}) + 11'sd127;
    if (q[26]) return round_pack(s, e, {q[26:1], q[0] | st});
    return round_pack(s, e - 11'sd1, {q[25:0], st});
  endfunction

  function automatic logic [31:0] fp_addsub(input logic [31:0] a, input logic [31:0] b_in,
                                            input logic op);
    logic [31:0]        b, big, sml;
    logic               za, zb, ia, ib, sticky;
    logic [7:0]         d;
    logic [26:0]        mx, sy;
    logic [53:0]        sh;
    logic [27:0]        sum;
    logic [4:0]         lz;
    logic signed [10:0] e;
    b  = {b_in[31] ^ op, b_in[30:0]};
    za = (a[30:23] == 8'd0);
    zb = (b[30:23] == 8'd0);
    ia = (a[30:23] == 8'hFF);
    ib = (b[30:23] == 8'hFF);
    if ((ia && a[22:0] != 23'd0) || (ib && b[22:0] != 23'd0)) return QNAN;
    if (ia && ib) return (a[31] != b[31]) ? QNAN : a;
    if (ia) return a;
    if (ib) return b;
    if (za && zb) return {a[31] & b[31], 31'd0};
    if (za) return b;
    if (zb) return a;
    if (b[30:0] > a[30:0]) begin
      big = b;
      sml = a;
    end else begin
      big = a;
      sml = b;
    end
    d      = big[30:23] - sml[30:23];
    mx     = {1'b1, big[22:0], 3'b000};
    sh     = {1'b1, sml[22:0], 3'b000, 27'd0} >> d;
    sticky = (|sh[26:0]) | (d >= 8'd54);
    sy     = {sh[53:28], sh[27] | sticky};
    sum    = (big[31] == sml[31]) ? {1'b0, mx} + {1'b0, sy} : {1'b0, mx} - {1'b0, sy};
    e      = $signed({3'b0, big[30:23]});
    if (sum == 28'd0) return 32'd0;
    if (sum[27]) return round_pack(big[31], e + 11'sd1, {sum[27:2], sum[1] | sum[0]});
    lz = 5'd0;
    for (int i = 0; i < 27; i++) if (sum[i]) lz = 5'(26 - i);
    return round_pack(big[31], e - $signed({6'd0, lz}), sum[26:0] << lz);
  endfunction
endpackage

module multiply #(parameter int LAT = 5) (
  input  logic        clk,
  input  logic        ce,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] y
);
  import complex_divide_seq_pkg::*;
  logic [31:0] pipe [LAT];
  always_ff @(posedge clk) begin
    if (ce) begin
      pipe[0] <= fp_mul(a, b);
      for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    end
  end
  assign y = pipe[LAT-1];
endmodule

module adder_subtractor #(parameter int LAT = 7) (
  input  logic        clk,
  input  logic        ce,
  input  logic        op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] y
);
  import complex_divide_seq_pkg::*;
  logic [31:0] pipe [LAT];
  always_ff @(posedge clk) begin
    if (ce) begin
      pipe[0] <= fp_addsub(a, b, op);
      for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    end
  end
  assign y = pipe[LAT-1];
endmodule

module fp_divide #(parameter int LAT = 15) (
  input  logic        clk,
  input  logic        ce,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] y
);
  import complex_divide_seq_pkg::*;
  logic [31:0] pipe [LAT];
  always_ff @(posedge clk) begin
    if (ce) begin
      pipe[0] <= fp_div(a, b);
      for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    end
  end
  assign y = pipe[LAT-1];
endmodule

module complex_divide_seq #(
  parameter int MUL_LAT = 5,
  parameter int ADD_LAT = 7,
  parameter int DIV_LAT = 15
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ce,
  complex_divide_seq_if.slave   bus
);
  import complex_divide_seq_pkg::*;

  typedef enum logic [3:0] {IDLE, SQ, DEN, MR, NR, MI, NI, DVR, DVI, DONE} state_t;
  state_t state, state_nxt;

  logic [7:0]  cnt;
  logic        tc, den_zero, add_op, dbz;
  logic [31:0] ar, ai, br, bi, t1, t2, den, nr, ni, qr;
  logic [31:0] m1_a, m1_b, m2_a, m2_b, div_a, m1_y, m2_y, add_y, div_y;
  logic [63:0] result;

  function automatic logic [7:0] lat_of(input state_t s);
    case (s)
      SQ, MR, MI: return 8'(MUL_LAT);
      DEN, NR, NI: return 8'(ADD_LAT);
      DVR, DVI: return 8'(DIV_LAT);
      default: return 8'd0;
    endcase
  endfunction

  assign tc       = (cnt == 8'd0);
  assign den_zero = (add_y[30:0] == 31'd0);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (bus.start) state_nxt = SQ;
      SQ:   if (tc) state_nxt = DEN;
      DEN:  if (tc) state_nxt = den_zero ? DONE : MR;
      MR:   if (tc) state_nxt = NR;
      NR:   if (tc) state_nxt = MI;
      MI:   if (tc) state_nxt = NI;
      NI:   if (tc) state_nxt = DVR;
      DVR:  if (tc) state_nxt = DVI;
      DVI:  if (tc) state_nxt = DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Core operands come straight from registers, so they are stable for the whole state.
  always_comb begin
    m1_a = br;
    m1_b = br;
    m2_a = bi;
    m2_b = bi;
    case (state)
      MR: begin m1_a = ar; m2_a = ai; end
      MI: begin m1_a = ai; m2_a = ar; end
      default: ;
    endcase
    add_op = (state == NI);
    div_a  = (state == DVI) ? ni : nr;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= 8'd0;
      result <= 64'd0;
      dbz    <= 1'b0;
      {ar, ai, br, bi} <= '0;
      {t1, t2, den, nr, ni, qr} <= '0;
    end else if (ce) begin
      state <= state_nxt;
      if (state_nxt != state) cnt <= lat_of(state_nxt);
      else if (!tc)           cnt <= cnt - 8'd1;
      case (state)
        IDLE: if (bus.start) {ar, ai, br, bi} <= {bus.A, bus.B};
        SQ, MR, MI: if (tc) begin
          t1 <= m1_y;
          t2 <= m2_y;
        end
        DEN: if (tc) begin
          den <= add_y;
          if (den_zero) begin
            result <= {QNAN, QNAN};
            dbz    <= 1'b1;
          end
        end
        NR:  if (tc) nr <= add_y;
        NI:  if (tc) ni <= add_y;
        DVR: if (tc) qr <= div_y;
        DVI: if (tc) begin
          result <= {qr, div_y};
          dbz    <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  multiply #(.LAT(MUL_LAT)) u_mul1 (.clk(clk), .ce(ce), .a(m1_a), .b(m1_b), .y(m1_y));
  multiply #(.LAT(MUL_LAT)) u_mul2 (.clk(clk), .ce(ce), .a(m2_a), .b(m2_b), .y(m2_y));
  adder_subtractor #(.LAT(ADD_LAT)) u_add (.clk(clk), .ce(ce), .op(add_op), .a(t1), .b(t2),
                                           .y(add_y));
  fp_divide #(.LAT(DIV_LAT)) u_div (.clk(clk), .ce(ce), .a(div_a), .b(den), .y(div_y));

  assign bus.result      = result;
  assign bus.div_by_zero = dbz;
  assign bus.done        = (state == DONE);
  assign bus.busy        = (state != IDLE) && (state != DONE);
endmodule

// File: tb/tb_complex_divide_seq.sv
// Directed bench for complex_divide_seq: latencies, results, ignored starts, ce stalls, reset abort.
module tb_complex_divide_seq;
  logic clk = 1'b0;
  logic rst;
  logic ce;
  int   vectors = 0;
  int   errors  = 0;

  complex_divide_seq_if bus ();
  complex_divide_seq dut (.clk(clk), .rst(rst), .ce(ce), .bus(bus));

  always #5 clk = ~clk;

  localparam logic [63:0] A_34 = 64'h40400000_40800000;  // 3+4i
  localparam logic [63:0] B_12 = 64'h3F800000_40000000;  // 1+2i
  localparam logic [63:0] Q_1  = 64'h400CCCCD_BECCCCCD;  // 2.2-0.4i
  localparam logic [63:0] A_2  = 64'h40000000_00000000;  // 2
  localparam logic [63:0] B_I  = 64'h00000000_3F800000;  // i
  localparam logic [63:0] Q_2  = 64'h00000000_C0000000;  // -2i
  localparam logic [63:0] NAN2 = 64'h7FC00000_7FC00000;
  localparam logic [63:0] A_X  = 64'h3F800000_3F800000;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Cycle 0 is the cycle start is driven high; done_cyc is the cycle done is first seen.
  task automatic run_op(input logic [63:0] a, input logic [63:0] b, input logic [63:0] alt_a,
                        input int p1, input int p2, input int ce_lo, input int ce_hi,
                        input int rst_cyc, output int done_cyc, output logic busy_bad,
                        output logic rst_bad);
    int cyc;
    done_cyc = -1;
    busy_bad = 1'b0;
    rst_bad  = 1'b0;
    @(posedge clk); #1;
    cyc       = 0;
    bus.A     = a;
    bus.B     = b;
    bus.start = 1'b1;
    ce        = 1'b1;
    while (done_cyc < 0 && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
      if (bus.done) begin
        done_cyc = cyc;
        if (bus.busy) busy_bad = 1'b1;
      end else if (rst_cyc >= 0 && cyc > rst_cyc) begin
        if (bus.busy) rst_bad = 1'b1;
      end else if (!bus.busy) begin
        busy_bad = 1'b1;
      end
      bus.start = (cyc == p1) || (cyc == p2);
      if (bus.start) bus.A = alt_a;
      ce  = !(cyc >= ce_lo && cyc <= ce_hi);
      rst = (cyc == rst_cyc);
    end
    bus.start = 1'b0;
    ce        = 1'b1;
    rst       = 1'b0;
  endtask

  initial begin
    int   dc;
    logic bb, rb;
    rst = 1'b1; ce = 1'b1; bus.start = 1'b0; bus.A = '0; bus.B = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("reset_result", bus.result, 64'd0);
    chk("reset_busy", 64'(bus.busy), 64'd0);
    chk("reset_done", 64'(bus.done), 64'd0);
    chk("reset_dbz", 64'(bus.div_by_zero), 64'd0);

    run_op(A_34, B_12, A_34, -1, -1, -1, -1, -1, dc, bb, rb);
    chk("op1_latency", 64'(dc), 64'd75);
    chk("op1_result", bus.result, Q_1);
    chk("op1_dbz", 64'(bus.div_by_zero), 64'd0);
    chk("op1_busy_window", 64'(bb), 64'd0);

    run_op(A_2, B_I, A_2, -1, -1, -1, -1, -1, dc, bb, rb);
    chk("op2_latency", 64'(dc), 64'd75);
    chk("op2_result", bus.result, Q_2);

    run_op(A_34, 64'd0, A_34, -1, -1, -1, -1, -1, dc, bb, rb);
    chk("dbz_latency", 64'(dc), 64'd15);
    chk("dbz_result", bus.result, NAN2);
    chk("dbz_flag", 64'(bus.div_by_zero), 64'd1);
    chk("dbz_busy_window", 64'(bb), 64'd0);

    run_op(A_2, B_I, A_2, -1, -1, -1, -1, -1, dc, bb, rb);
    chk("after_dbz_result", bus.result, Q_2);
    chk("after_dbz_flag", 64'(bus.div_by_zero), 64'd0);

    run_op(A_34, B_12, A_X, 10, 74, -1, -1, -1, dc, bb, rb);
    chk("ignored_start_latency", 64'(dc), 64'd75);
    chk("ignored_start_result", bus.result, Q_1);

    run_op(A_2, B_I, A_2, -1, -1, -1, -1, -1, dc, bb, rb);
    chk("back_to_back_latency", 64'(dc), 64'd75);
    chk("back_to_back_result", bus.result, Q_2);

    run_op(A_34, B_12, A_34, -1, -1, 20, 29, -1, dc, bb, rb);
    chk("ce_stall_latency", 64'(dc), 64'd85);
    chk("ce_stall_result", bus.result, Q_1);
    chk("ce_stall_busy_window", 64'(bb), 64'd0);

    run_op(A_2, B_I, A_2, -1, -1, -1, -1, 40, dc, bb, rb);
    chk("rst_abort_no_done", 64'(dc), 64'hFFFF_FFFF_FFFF_FFFF);
    chk("rst_abort_busy_low", 64'(rb), 64'd0);
    chk("rst_abort_result_cleared", bus.result, 64'd0);

    run_op(A_34, B_12, A_34, -1, -1, -1, -1, -1, dc, bb, rb);
    chk("after_rst_latency", 64'(dc), 64'd75);
    chk("after_rst_result", bus.result, Q_1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule

// File: doc/complex_divide_seq.md
# complex_divide_seq

Sequential complex divider for the 64-bit packed complex format used by the complex arithmetic datapath: real part in [63:32], imaginary part in [31:0], both IEEE-754 single precision. It computes A/B as A·conj(B)/|B|², the inverse of the complex multiply blocks. It time-multiplexes two `multiply` cores, one `adder_subtractor` and one floating-point divide core under an FSM, and uses a start/busy/done handshake. It sits beside the multiply blocks and is driven by the solver control logic.

## Interface
- MUL_LAT, 5: pipeline latency of `multiply` in clock-enabled cycles
- ADD_LAT, 7: pipeline latency of `adder_subtractor`
- DIV_LAT, 15: pipeline latency of the float divide core
- clk  in  1  rising-edge clock; the block uses one clock only
- rst  in  1  synchronous, active-high reset
- ce  in  1  global clock enable; low freezes the FSM, counters and all core `ce` inputs
- start  in  1  request; sampled only when busy=0 and ce=1
- A  in  64  dividend {real, imag}
- B  in  64  divisor {real, imag}
- result  out  64  quotient {real, imag}; held until the next done
- busy  out  1  high from the cycle after start is accepted until done
- done  out  1  one-cycle pulse; result valid in the same cycle
- div_by_zero  out  1  valid with done; 1 when |B|² evaluated to ±0

## Operation
- On accepted start, latch A and B into operand registers (ar, ai, br, bi). Ignore later input changes.
- FSM states: IDLE, SQ, DEN, MR, NR, MI, NI, DVR, DVI, DONE.
- SQ: m1=br·br, m2=bi·bi.
- DEN: den = m1 + m2 (add/sub op 0).
- DEN end: if den[30:0]==0, go to DONE with result = 64'h7FC00000_7FC00000 (qNaN, qNaN) and div_by_zero=1. Otherwise go to MR.
- MR: ar·br and ai·bi. NR: nr = sum (op 0).
- MI: ai·br and ar·bi. NI: ni = ai·br − ar·bi (op 1).
- DVR: qr = nr/den. DVI: qi = ni/den.
- DONE: result = {qr, qi}, div_by_zero=0, done=1. Return to IDLE on the next cycle.
- Core operands are driven from registers and held constant for the whole state.
- No denormal or NaN handling beyond what the cores do. Infinite or NaN operands pass through the cores unchanged.
- start while busy=1 is ignored; it is neither queued nor acknowledged.
- start in the DONE cycle is ignored. It is accepted again from IDLE, so back-to-back operations have a 1-cycle gap.

## Timing
- Reset values: result=0, busy=0, done=0, div_by_zero=0, state=IDLE, counter=0.
- Reset mid-operation aborts immediately with no done. In-flight core pipeline contents are discarded, because the counter restarts from zero on the next start.
- Each compute state lasts (core latency + 1) enabled cycles. The core output is captured on the final edge of the state.
- Latency (ce held high), counted from the start-sampling edge to the done cycle: N = 3(MUL_LAT+1) + 3(ADD_LAT+1) + 2(DIV_LAT+1) + 1. With the defaults, N = 75.
- Divide-by-zero path: N = (MUL_LAT+1) + (ADD_LAT+1) + 1. With the defaults, N = 15.
- busy falls in the same cycle done is asserted.
- ce=0 cycles add exactly one cycle each to latency. done is asserted only when ce=1. If ce falls during DONE, done stays high until the next ce=1 edge, so it remains one enabled cycle long.
- rst has priority over ce: reset takes effect even when ce=0.

## Test plan
- A=40400000_40800000 (3+4i), B=3F800000_40000000 (1+2i), ce=1 -> done at cycle 75, result=400CCCCD_BECCCCCD (2.2−0.4i), div_by_zero=0, busy high for cycles 1–74.
- A=40000000_00000000 (2), B=00000000_3F800000 (i) -> result=00000000_C0000000 (−2i), done at cycle 75.
- B=0 (A arbitrary) -> done at cycle 15, result=7FC00000_7FC00000, div_by_zero=1. A subsequent valid start gives normal results.
- Pulse start again at cycles 10 and 74 with a different A -> ignored; the first result is unchanged. A start at cycle 76 is accepted and its done arrives 75 cycles later.
- Drop ce for cycles 20–29 during the 3+4i case -> done at cycle 85 with the same result. The core ce pins are low for exactly those 10 cycles.
- Assert rst at cycle 40 -> busy=0 and done=0 from cycle 41, with no done pulse. The next start completes in 75 cycles with the correct result.
